// File: rtl/mul_rs_pkg.sv
// Shared types and constants for the multiply/divide reservation station.
package mul_rs_pkg;

  localparam int unsigned ENTRIES = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TAG_W   = 3;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned OCC_W   = $clog2(ENTRIES + 1);

  localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;

  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
    logic [TAG_W-1:0]  tag;
  } src_t;

  typedef struct packed {
    logic              valid;
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    src_t              src1;
    src_t              src2;
  } entry_t;

  // Fields handed to the execution unit on dispatch.
  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
  } disp_t;

  function automatic logic func_supported(input logic [FUNC_W-1:0] f);
    return (f == FUNC_MUL) || (f == FUNC_DIV);
  endfunction

  function automatic src_t src_capture(input src_t s, input logic cdb_valid,
                                       input logic [TAG_W-1:0] cdb_tag,
                                       input logic [DATA_W-1:0] cdb_data);
    src_t r;
    r = s;
    if (!s.rdy && cdb_valid && (s.tag == cdb_tag)) begin
      r.rdy = 1'b1;
      r.val = cdb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_rs_dispatch_if.sv
// Issue / CDB / execution-unit bundle of the MUL/DIV reservation station.
interface mul_rs_dispatch_if;
  import mul_rs_pkg::*;

  logic              flush;
  logic              issue_valid;
  logic              issue_ready;
  logic [FUNC_W-1:0] issue_func;
  logic [REG_W-1:0]  issue_rd;
  logic [TAG_W-1:0]  issue_rob;
  logic              issue_src1_rdy;
  logic              issue_src2_rdy;
  logic [DATA_W-1:0] issue_src1_val;
  logic [DATA_W-1:0] issue_src2_val;
  logic [TAG_W-1:0]  issue_src1_tag;
  logic [TAG_W-1:0]  issue_src2_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              ex_ready;
  logic              ex_b;
  logic [TAG_W-1:0]  rs_index;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [FUNC_W-1:0] func;
  logic [TAG_W-1:0]  rob_ind;
  logic [REG_W-1:0]  rd;
  logic [OCC_W-1:0]  occupancy;
  logic              bad_func;

  modport master (
    output flush, issue_valid, issue_func, issue_rd, issue_rob,
           issue_src1_rdy, issue_src2_rdy, issue_src1_val, issue_src2_val,
           issue_src1_tag, issue_src2_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
    input  issue_ready, ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd,
           occupancy, bad_func
  );

  modport slave (
    input  flush, issue_valid, issue_func, issue_rd, issue_rob,
           issue_src1_rdy, issue_src2_rdy, issue_src1_val, issue_src2_val,
           issue_src1_tag, issue_src2_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
    output issue_ready, ex_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd,
           occupancy, bad_func
  );

endinterface

// File: rtl/mul_rs_entry.sv
// One reservation-station entry: storage, CDB tag match/capture, ready flag.
module mul_rs_entry
  import mul_rs_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  entry_t            wr_data_i,
  input  logic              clr_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              valid_o,
  output logic              ready_o,
  output disp_t             payload_o
);

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid = 1'b0;
    end else if (wr_en_i) begin
      entry_d = wr_data_i;
    end else if (clr_i) begin
      entry_d.valid = 1'b0;
    end else if (entry_q.valid) begin
      entry_d.src1 = src_capture(entry_q.src1, cdb_valid_i, cdb_tag_i, cdb_data_i);
      entry_d.src2 = src_capture(entry_q.src2, cdb_valid_i, cdb_tag_i, cdb_data_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Ready reflects registered state, so a same-cycle wakeup is not yet eligible.
  assign valid_o        = entry_q.valid;
  assign ready_o        = entry_q.valid & entry_q.src1.rdy & entry_q.src2.rdy;
  assign payload_o.func = entry_q.func;
  assign payload_o.rd   = entry_q.rd;
  assign payload_o.rob  = entry_q.rob;
  assign payload_o.v1   = entry_q.src1.val;
  assign payload_o.v2   = entry_q.src2.val;

endmodule

// File: rtl/mul_rs_dispatch.sv
// MUL/DIV reservation station: issue into free slot, CDB wakeup, one dispatch per cycle.
// Optional MUL_RS_BYPASS_EN: capture a same-cycle CDB broadcast at issue time.
module mul_rs_dispatch
  import mul_rs_pkg::*;
(
  input logic                clk1,
  input logic                rst,
  mul_rs_dispatch_if.slave   bus
);

  logic [ENTRIES-1:0] valid, ready, wr_en, clr, free_oh, cand_oh;
  disp_t              payload [ENTRIES];
  entry_t             wr_entry;
  disp_t              cand;
  logic [TAG_W-1:0]   cand_idx;
  logic               free_found, cand_found, any_free, issue_fire, dispatch, supported;
  logic [OCC_W-1:0]   occ;

  logic              ex_b_q, ex_b_d, bad_func_q, bad_func_d;
  logic [TAG_W-1:0]  rs_index_q, rs_index_d;
  disp_t             out_q, out_d;

  always_comb begin
    free_oh    = '0;
    cand_oh    = '0;
    cand_idx   = '0;
    cand       = '0;
    free_found = 1'b0;
    cand_found = 1'b0;
    occ        = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      occ = occ + OCC_W'(valid[i]);
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
      end
      if (ready[i] && !cand_found) begin
        cand_found = 1'b1;
        cand_oh[i] = 1'b1;
        cand_idx   = TAG_W'(i);
        cand       = payload[i];
      end
    end
  end

  assign any_free = ~&valid;
`ifdef MUL_RS_BYPASS_EN
  assign bus.issue_ready = any_free;
`else
  // Without issue-time capture, stall issue while a broadcast is on the bus.
  assign bus.issue_ready = any_free & ~bus.cdb_valid;
`endif

  assign issue_fire = bus.issue_valid & bus.issue_ready;
  assign supported  = func_supported(bus.issue_func);

  always_comb begin
    wr_entry.valid    = 1'b1;
    wr_entry.func     = bus.issue_func;
    wr_entry.rd       = bus.issue_rd;
    wr_entry.rob      = bus.issue_rob;
    wr_entry.src1.rdy = bus.issue_src1_rdy;
    wr_entry.src1.val = bus.issue_src1_val;
    wr_entry.src1.tag = bus.issue_src1_tag;
    wr_entry.src2.rdy = bus.issue_src2_rdy;
    wr_entry.src2.val = bus.issue_src2_val;
    wr_entry.src2.tag = bus.issue_src2_tag;
`ifdef MUL_RS_BYPASS_EN
    wr_entry.src1 = src_capture(wr_entry.src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    wr_entry.src2 = src_capture(wr_entry.src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`endif
  end

  assign wr_en    = {ENTRIES{issue_fire & supported & ~bus.flush}} & free_oh;
  assign dispatch = cand_found & bus.ex_ready & ~bus.flush;
  assign clr      = dispatch ? cand_oh : '0;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    mul_rs_entry u_entry (
      .clk_i       (clk1),
      .rst_i       (rst),
      .flush_i     (bus.flush),
      .wr_en_i     (wr_en[i]),
      .wr_data_i   (wr_entry),
      .clr_i       (clr[i]),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (bus.cdb_tag),
      .cdb_data_i  (bus.cdb_data),
      .valid_o     (valid[i]),
      .ready_o     (ready[i]),
      .payload_o   (payload[i])
    );
  end

  always_comb begin
    ex_b_d     = dispatch;
    out_d      = dispatch ? cand : out_q;
    rs_index_d = dispatch ? cand_idx : rs_index_q;
    bad_func_d = issue_fire & ~supported & ~bus.flush;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ex_b_q     <= 1'b0;
      out_q      <= '0;
      rs_index_q <= '0;
      bad_func_q <= 1'b0;
    end else begin
      ex_b_q     <= ex_b_d;
      out_q      <= out_d;
      rs_index_q <= rs_index_d;
      bad_func_q <= bad_func_d;
    end
  end

  assign bus.ex_b      = ex_b_q;
  assign bus.rs_index  = rs_index_q;
  assign bus.rs1_data  = out_q.v1;
  assign bus.rs2_data  = out_q.v2;
  assign bus.func      = out_q.func;
  assign bus.rob_ind   = out_q.rob;
  assign bus.rd        = out_q.rd;
  assign bus.bad_func  = bad_func_q;
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Directed bench for mul_rs_dispatch; expectations are hand-computed per scenario.
module tb_mul_rs_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mul_rs_dispatch_if bus ();

  mul_rs_dispatch dut (
    .clk1 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                           input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                           input logic r2, input logic [7:0] v2, input logic [2:0] t2);
    bus.issue_func     = f;
    bus.issue_rd       = rd;
    bus.issue_rob      = rob;
    bus.issue_src1_rdy = r1;
    bus.issue_src1_val = v1;
    bus.issue_src1_tag = t1;
    bus.issue_src2_rdy = r2;
    bus.issue_src2_val = v2;
    bus.issue_src2_tag = t2;
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                       input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                       input logic r2, input logic [7:0] v2, input logic [2:0] t2);
    set_issue(f, rd, rob, r1, v1, t1, r2, v2, t2);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic v, input logic [2:0] tag, input logic [7:0] data);
    bus.cdb_valid = v;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  initial begin
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.ex_ready    = 1'b0;
    set_issue(4'h0, 4'h0, 3'h0, 1'b0, 8'h0, 3'h0, 1'b0, 8'h0, 3'h0);
    cdb(1'b0, 3'h0, 8'h0);
    step();
    step();

    // Reset state
    check("rst_ex_b", bus.ex_b, 0);
    check("rst_rs_index", bus.rs_index, 0);
    check("rst_rs1", bus.rs1_data, 0);
    check("rst_rs2", bus.rs2_data, 0);
    check("rst_func", bus.func, 0);
    check("rst_rob", bus.rob_ind, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_bad_func", bus.bad_func, 0);
    check("rst_issue_ready", bus.issue_ready, 1);
    rst = 1'b0;
    bus.ex_ready = 1'b1;

    // Ready MUL dispatches one edge after issue
    issue(4'b0010, 4'd5, 3'd2, 1'b1, 8'd3, 3'd0, 1'b1, 8'd4, 3'd0);
    check("t1_occ_after_issue", bus.occupancy, 1);
    check("t1_no_strobe_yet", bus.ex_b, 0);
    step();
    check("t1_ex_b", bus.ex_b, 1);
    check("t1_rs1", bus.rs1_data, 3);
    check("t1_rs2", bus.rs2_data, 4);
    check("t1_func", bus.func, 4'b0010);
    check("t1_rob", bus.rob_ind, 2);
    check("t1_rd", bus.rd, 5);
    check("t1_rs_index", bus.rs_index, 0);
    check("t1_occ_after_disp", bus.occupancy, 0);
    step();
    check("t1_strobe_pulse", bus.ex_b, 0);
    check("t1_rs1_hold", bus.rs1_data, 3);

    // DIV waiting on tag 6
    issue(4'b0011, 4'd1, 3'd3, 1'b1, 8'd8, 3'd0, 1'b0, 8'd0, 3'd6);
    step();
    check("t2_waiting", bus.ex_b, 0);
    cdb(1'b1, 3'd6, 8'h02);
    #1;
`ifdef MUL_RS_BYPASS_EN
    check("t2_issue_ready_cdb", bus.issue_ready, 1);
`else
    check("t2_issue_ready_cdb", bus.issue_ready, 0);
`endif
    step();
    cdb(1'b0, 3'd0, 8'h0);
    check("t2_wake_not_eligible", bus.ex_b, 0);
    step();
    check("t2_ex_b", bus.ex_b, 1);
    check("t2_rs2", bus.rs2_data, 8'h02);
    check("t2_rs1", bus.rs1_data, 8);
    check("t2_func", bus.func, 4'b0011);
    check("t2_rob", bus.rob_ind, 3);
    check("t2_rs_index", bus.rs_index, 0);
    step();

    // Fill three unready entries, fourth issue ignored
    bus.ex_ready = 1'b0;
    issue(4'b0010, 4'd1, 3'd4, 1'b0, 8'd0, 3'd1, 1'b1, 8'd7, 3'd0);
    issue(4'b0010, 4'd2, 3'd5, 1'b0, 8'd0, 3'd2, 1'b1, 8'd7, 3'd0);
    issue(4'b0011, 4'd3, 3'd6, 1'b0, 8'd0, 3'd3, 1'b1, 8'd7, 3'd0);
    check("t3_occ_full", bus.occupancy, 3);
    check("t3_issue_ready_full", bus.issue_ready, 0);
    issue(4'b0010, 4'd4, 3'd7, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    check("t3_full_ignored", bus.occupancy, 3);
    check("t3_no_strobe", bus.ex_b, 0);
    bus.ex_ready = 1'b1;
    cdb(1'b1, 3'd2, 8'h11);
    step();
    cdb(1'b0, 3'd0, 8'h0);
    check("t3_wake_not_eligible", bus.ex_b, 0);
    step();
    check("t3_ex_b", bus.ex_b, 1);
    check("t3_rs_index", bus.rs_index, 1);
    check("t3_rs1", bus.rs1_data, 8'h11);
    check("t3_rob", bus.rob_ind, 5);
    check("t3_occ", bus.occupancy, 2);
    check("t3_issue_ready", bus.issue_ready, 1);

    // Unsupported opcode
    issue(4'b0111, 4'd9, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    check("t6_bad_func", bus.bad_func, 1);
    check("t6_bad_occ", bus.occupancy, 2);
    step();
    check("t6_bad_func_pulse", bus.bad_func, 0);

    // Flush beats dispatch of the woken entry 0 and a new issue
    cdb(1'b1, 3'd1, 8'h22);
    step();
    cdb(1'b0, 3'd0, 8'h0);
    bus.flush = 1'b1;
    set_issue(4'b0010, 4'd6, 3'd6, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    bus.issue_valid = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    check("t6_flush_ex_b", bus.ex_b, 0);
    check("t6_flush_occ", bus.occupancy, 0);
    check("t6_flush_rs_index_hold", bus.rs_index, 1);
    step();
    check("t6_flush_ex_b_after", bus.ex_b, 0);
    check("t6_flush_occ_after", bus.occupancy, 0);

    // Stalled execution unit, then back-to-back dispatch
    bus.ex_ready = 1'b0;
    issue(4'b0010, 4'd1, 3'd1, 1'b1, 8'd1, 3'd0, 1'b1, 8'd2, 3'd0);
    issue(4'b0011, 4'd2, 3'd2, 1'b1, 8'd5, 3'd0, 1'b1, 8'd6, 3'd0);
    step();
    check("t4_stall_ex_b", bus.ex_b, 0);
    check("t4_stall_occ", bus.occupancy, 2);
    bus.ex_ready = 1'b1;
    step();
    check("t4_first_ex_b", bus.ex_b, 1);
    check("t4_first_index", bus.rs_index, 0);
    check("t4_first_rs1", bus.rs1_data, 1);
    step();
    check("t4_second_ex_b", bus.ex_b, 1);
    check("t4_second_index", bus.rs_index, 1);
    check("t4_second_rs1", bus.rs1_data, 5);
    check("t4_second_func", bus.func, 4'b0011);
    step();
    check("t4_done_ex_b", bus.ex_b, 0);
    check("t4_done_occ", bus.occupancy, 0);

    // Issue concurrent with a matching broadcast
    cdb(1'b1, 3'd4, 8'h09);
    set_issue(4'b0010, 4'd2, 3'd7, 1'b0, 8'd0, 3'd4, 1'b1, 8'd1, 3'd0);
    bus.issue_valid = 1'b1;
    #1;
`ifdef MUL_RS_BYPASS_EN
    check("t5_issue_ready", bus.issue_ready, 1);
    step();
    bus.issue_valid = 1'b0;
    cdb(1'b0, 3'd0, 8'h0);
    check("t5_occ", bus.occupancy, 1);
    step();
    check("t5_ex_b", bus.ex_b, 1);
    check("t5_rs1_bypass", bus.rs1_data, 8'h09);
`else
    check("t5_issue_ready", bus.issue_ready, 0);
    step();
    bus.issue_valid = 1'b0;
    cdb(1'b0, 3'd0, 8'h0);
    check("t5_occ", bus.occupancy, 0);
    step();
    check("t5_ex_b", bus.ex_b, 0);
`endif

    // Asynchronous reset mid-operation
    bus.ex_ready = 1'b0;
    issue(4'b0010, 4'd9, 3'd5, 1'b1, 8'h33, 3'd0, 1'b1, 8'h44, 3'd0);
    check("t7_occ_before", bus.occupancy, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_occ", bus.occupancy, 0);
    check("t7_ex_b", bus.ex_b, 0);
    check("t7_rs1", bus.rs1_data, 0);
    check("t7_rd", bus.rd, 0);
    check("t7_issue_ready", bus.issue_ready, 1);
    step();
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
